// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the register file slice.
//   REG_BUS_W / REG_ADDR_W / REG_NUM / REG_NUM_LOG2 : storage geometry
//   ZERO_WORD, RST_ENABLE, WRITE_ENABLE, READ_ENABLE, NOP_REG_ADDR : level/value constants
//   rd_sel_e : which source a read port is currently returning
package regfile_pkg;

  localparam int REG_BUS_W    = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int REG_NUM      = 32;
  localparam int REG_NUM_LOG2 = 5;

  localparam logic [REG_BUS_W-1:0]  ZERO_WORD    = '0;
  localparam logic                  RST_ENABLE   = 1'b1;
  localparam logic                  WRITE_ENABLE = 1'b1;
  localparam logic                  READ_ENABLE  = 1'b1;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

  typedef enum logic [2:0] {
    SEL_RST    = 3'd0,
    SEL_OFF    = 3'd1,
    SEL_ZERO   = 3'd2,
    SEL_BYPASS = 3'd3,
    SEL_MEM    = 3'd4
  } rd_sel_e;

endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one combinational read-port mux.
//   Inputs : rst, re, raddr, we, waddr, wdata (write-back triple), mem_data (mem[raddr])
//   Output : rdata
// Priority: reset -> disabled -> index 0 -> same-cycle bypass -> stored value.
// Bypass is present only when REGFILE_BYPASS_EN is defined.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] rdata
);

  rd_sel_e sel;
  logic    bypass_hit;

`ifdef REGFILE_BYPASS_EN
  // Index-0 case is already filtered above the bypass in the priority chain.
  assign bypass_hit = (we == WRITE_ENABLE) && (waddr == raddr);
`else
  logic unused_bypass;
  assign unused_bypass = ^{we, waddr};
  assign bypass_hit    = 1'b0;
`endif

  always_comb begin
    sel = SEL_MEM;
    if (rst == RST_ENABLE)                   sel = SEL_RST;
    else if (re != READ_ENABLE)              sel = SEL_OFF;
    else if (raddr == ADDR_W'(NOP_REG_ADDR)) sel = SEL_ZERO;
    else if (bypass_hit)                     sel = SEL_BYPASS;
  end

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_BYPASS: rdata = wdata;
      SEL_MEM:    rdata = mem_data;
      default:    rdata = '0;
    endcase
  end

endmodule

// File: rtl/regfile.sv
// regfile: 32 x 32-bit general-purpose register file, $0 hardwired to zero.
//   clk, rst (async, active-high)
//   we, waddr, wdata     : write-back port, written on rising clk edge
//   re1, raddr1 -> rdata1: combinational read port 1
//   re2, raddr2 -> rdata2: combinational read port 2
// Optional macro REGFILE_BYPASS_EN: read ports forward wdata when writing the
// same non-zero index in the same cycle.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REG_BUS_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem_reg [NUM_REGS];

  // Entire array must clear asynchronously, so this stays in flops, not RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < NUM_REGS; i++) mem_reg[i] <= '0;
    end else if ((we == WRITE_ENABLE) && (waddr != ADDR_W'(NOP_REG_ADDR))) begin
      mem_reg[waddr] <= wdata;
    end
  end

  logic              re_arr    [2];
  logic [ADDR_W-1:0] raddr_arr [2];
  logic [DATA_W-1:0] rdata_arr [2];

  assign re_arr[0]    = re1;
  assign re_arr[1]    = re2;
  assign raddr_arr[0] = raddr1;
  assign raddr_arr[1] = raddr2;
  assign rdata1       = rdata_arr[0];
  assign rdata2       = rdata_arr[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rdport
      regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
      ) u_rdport (
        .rst      (rst),
        .re       (re_arr[gi]),
        .raddr    (raddr_arr[gi]),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .mem_data (mem_reg[raddr_arr[gi]]),
        .rdata    (rdata_arr[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed self-checking bench for regfile.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  int checks;
  int failures;

  regfile dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One write transaction: drive on negedge, commit on the next posedge.
  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0; waddr = '0; wdata = '0;
  endtask

  task automatic test_reset;
    write_reg(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    re1 = 1'b1; raddr1 = 5'd5;
    #1;
    checks++;
    if (rdata1 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL reset_preload got=%h exp=%h", rdata1, 32'hDEADBEEF);
    end
    rst = 1'b1;  // no clock edge between here and the check
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_async_read got=%h exp=%h", rdata1, 32'h0);
    end
    $display("reset: r5 read under rst = %h", rdata1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i < 32; i++) begin
      raddr1 = 5'(i);
      #1;
      checks++;
      if (rdata1 !== 32'h0) begin
        failures++;
        $display("FAIL reset_clear r%0d got=%h exp=%h", i, rdata1, 32'h0);
      end
    end
    $display("reset: r1..r31 scanned after release");
  endtask

  task automatic test_write_read;
    write_reg(5'd3, 32'h12345678);
    @(negedge clk);
    re1 = 1'b1; raddr1 = 5'd3;
    #1;
    checks++;
    if (rdata1 !== 32'h12345678) begin
      failures++;
      $display("FAIL write_read got=%h exp=%h", rdata1, 32'h12345678);
    end
    re1 = 1'b0;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL read_disabled got=%h exp=%h", rdata1, 32'h0);
    end
    $display("write_read: r3 en=%h dis=%h", 32'h12345678, rdata1);
    re1 = 1'b1;
  endtask

  task automatic test_zero_reg;
    @(negedge clk);
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      failures++;
      $display("FAIL zero_same_cycle got=%h/%h exp=0/0", rdata1, rdata2);
    end
    @(posedge clk);
    #1;
    we = 1'b0; wdata = '0;
    #1;
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      failures++;
      $display("FAIL zero_next_cycle got=%h/%h exp=0/0", rdata1, rdata2);
    end
    $display("zero_reg: r0 after write = %h/%h", rdata1, rdata2);
  endtask

  task automatic test_forwarding;
    logic [31:0] exp_n;
    write_reg(5'd7, 32'h11111111);
`ifdef REGFILE_BYPASS_EN
    exp_n = 32'h22222222;
`else
    exp_n = 32'h11111111;
`endif
    @(negedge clk);
    we = 1'b1; waddr = 5'd7; wdata = 32'h22222222;
    re2 = 1'b1; raddr2 = 5'd7;
    #1;
    checks++;
    if (rdata2 !== exp_n) begin
      failures++;
      $display("FAIL forward_cycle_n got=%h exp=%h", rdata2, exp_n);
    end
    @(posedge clk);
    #1;
    we = 1'b0; waddr = '0; wdata = '0;
    #1;
    checks++;
    if (rdata2 !== 32'h22222222) begin
      failures++;
      $display("FAIL forward_cycle_n1 got=%h exp=%h", rdata2, 32'h22222222);
    end
    $display("forwarding: r7 cycle N=%h N+1=%h", exp_n, rdata2);
  endtask

  task automatic test_dual_port;
    write_reg(5'd9, 32'hA5A5A5A5);
    @(negedge clk);
    re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd9; raddr2 = 5'd9;
    #1;
    checks++;
    if (rdata1 !== 32'hA5A5A5A5 || rdata2 !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL dual_same_index got=%h/%h exp=%h", rdata1, rdata2, 32'hA5A5A5A5);
    end
    // Distinct indices on the two ports.
    raddr1 = 5'd3;
    #1;
    checks++;
    if (rdata1 !== 32'h12345678 || rdata2 !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL dual_diff_index got=%h/%h exp=%h/%h", rdata1, rdata2,
               32'h12345678, 32'hA5A5A5A5);
    end
    $display("dual_port: r9 on both ports = %h", rdata2);
  endtask

  task automatic test_reset_vs_write;
    @(negedge clk);
    we = 1'b1; waddr = 5'd4; wdata = 32'hCAFEF00D;
    re1 = 1'b1; raddr1 = 5'd4;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL rst_vs_write_during got=%h exp=%h", rdata1, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL rst_vs_write_after got=%h exp=%h", rdata1, 32'h0);
    end
    // Earlier contents must also be gone.
    raddr1 = 5'd9;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL rst_clears_r9 got=%h exp=%h", rdata1, 32'h0);
    end
    $display("reset_vs_write: r4 after release = %h", rdata1);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd1; raddr2 = 5'd2;
    #1;
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      failures++;
      $display("FAIL initial_reset got=%h/%h exp=0/0", rdata1, rdata2);
    end
    rst = 1'b0;

    test_reset;
    test_write_read;
    test_zero_reg;
    test_forwarding;
    test_dual_port;
    test_reset_vs_write;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
